// File: rtl/axi_wr_arbiter_rr.sv
// ---------------------------------------------------------------------------
// axi_wr_arbiter_rr
//
// Round-robin arbiter for the shared AXI write path (AW/W/B). One master at a
// time owns the path for exactly one write transaction, from its AW request
// until the B handshake. A stall watchdog aborts a hung transaction, raises a
// sticky error flag and returns the arbiter to idle. The block only produces
// grant information; the interconnect muxes use it to steer AW/W/B.
//
// Parameters
//   NUM_MASTERS  number of masters (2..16)
//   ID_W         width of grnt_id
//   TIMEOUT      watchdog limit in cycles, 0 disables the watchdog
//
// Ports
//   ACLK         clock, everything on the rising edge
//   ARESET       synchronous active-high reset
//   m_AWVALID    per-master AWVALID, also the request line of each master
//   m_WVALID     per-master WVALID
//   m_WLAST      per-master WLAST
//   m_BREADY     per-master BREADY
//   s_AWREADY    shared slave-side AWREADY
//   s_WREADY     shared slave-side WREADY
//   s_BVALID     shared slave-side BVALID
//   m_wgrnt      one-hot grant, all-zero when nobody owns the path
//   grnt_id      index of the current owner, meaningful while busy
//   busy         a transaction is in progress
//   timeout_err  sticky watchdog flag, cleared only by ARESET
// ---------------------------------------------------------------------------
module axi_wr_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int ID_W        = $clog2(NUM_MASTERS),
  parameter int TIMEOUT     = 1024
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic [NUM_MASTERS-1:0] m_AWVALID,
  input  logic [NUM_MASTERS-1:0] m_WVALID,
  input  logic [NUM_MASTERS-1:0] m_WLAST,
  input  logic [NUM_MASTERS-1:0] m_BREADY,
  input  logic                   s_AWREADY,
  input  logic                   s_WREADY,
  input  logic                   s_BVALID,
  output logic [NUM_MASTERS-1:0] m_wgrnt,
  output logic [ID_W-1:0]        grnt_id,
  output logic                   busy,
  output logic                   timeout_err
);

  // The watchdog counter only ever has to reach TIMEOUT-1, so log2(TIMEOUT)
  // bits are enough. A one-bit counter is kept when the watchdog is tiny or
  // disabled so that the declarations stay legal.
  localparam int              WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit              WD_EN    = (TIMEOUT > 0);
  localparam logic [WD_W-1:0] WD_LIMIT = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_RESP
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [ID_W-1:0] r_g;
  logic [ID_W-1:0] w_gNext;
  logic [ID_W-1:0] r_last;
  logic [ID_W-1:0] w_lastNext;
  logic            r_awDone;
  logic            w_awDoneNext;
  logic            r_wDone;
  logic            w_wDoneNext;
  logic [WD_W-1:0] r_wdCnt;
  logic [WD_W-1:0] w_wdCntNext;
  logic            r_timeoutErr;
  logic            w_timeoutErrNext;

  logic            w_anyReq;
  logic [ID_W-1:0] w_pickIdle;
  logic [ID_W-1:0] w_pickResp;
  logic            w_awHs;
  logic            w_wBeat;
  logic            w_wLastHs;
  logic            w_bHs;
  logic            w_ownerHs;
  logic            w_wdExpire;

  // Round-robin search: walk the indices ptr+1, ptr+2, ... wrapping at
  // NUM_MASTERS, and return the first one that is requesting. The pointer
  // itself is visited last, which gives the previous owner lowest priority.
  // The wrap is done by compare-and-reset rather than modulo so that
  // NUM_MASTERS need not be a power of two. If nobody requests the pointer is
  // returned unchanged; callers only use the result when a request exists.
  function automatic logic [ID_W-1:0] rrPick(
    input logic [NUM_MASTERS-1:0] req,
    input logic [ID_W-1:0]        ptr
  );
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] pick;
    logic            found;
    cand  = ptr;
    pick  = ptr;
    found = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (cand == ID_W'(NUM_MASTERS - 1)) begin
        cand = '0;
      end else begin
        cand = cand + ID_W'(1);
      end
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Requests are the AWVALID lines only; a W beat without AW is not a
  // request. Two winners are prepared: one from the stored pointer for the
  // idle case, and one from the current owner for the back-to-back handover
  // at the B handshake, where the pointer is about to become the owner.
  assign w_anyReq   = |m_AWVALID;
  assign w_pickIdle = rrPick(m_AWVALID, r_last);
  assign w_pickResp = rrPick(m_AWVALID, r_g);

  // Owner handshakes. Only the owner's lines are looked at, so activity from
  // other masters can never move the flags. AW and W beats are qualified by
  // their done flags: a master that keeps AWVALID high after its AW was taken
  // is already asking for its next transaction, not handshaking this one.
  // Every W beat (not just the last) counts as progress for the watchdog.
  assign w_awHs    = (r_state == ST_XFER) && !r_awDone && m_AWVALID[r_g] && s_AWREADY;
  assign w_wBeat   = (r_state == ST_XFER) && !r_wDone && m_WVALID[r_g] && s_WREADY;
  assign w_wLastHs = w_wBeat && m_WLAST[r_g];
  assign w_bHs     = (r_state == ST_RESP) && s_BVALID && m_BREADY[r_g];
  assign w_ownerHs = w_awHs || w_wBeat || w_bHs;

  // The watchdog trips when the counter has reached its limit and the owner
  // made no progress in this cycle either.
  assign w_wdExpire = WD_EN && (r_wdCnt == WD_LIMIT) && !w_ownerHs;

  // Next-state and next-value logic. The transaction flow is handled in the
  // case statement; the watchdog is applied afterwards so that an expiry
  // overrides whatever the flow would otherwise have done in that cycle.
  always_comb begin
    w_stateNext      = r_state;
    w_gNext          = r_g;
    w_lastNext       = r_last;
    w_awDoneNext     = r_awDone;
    w_wDoneNext      = r_wDone;
    w_wdCntNext      = r_wdCnt;
    w_timeoutErrNext = r_timeoutErr;

    case (r_state)
      ST_IDLE: begin
        w_wdCntNext = '0;
        if (w_anyReq) begin
          w_gNext      = w_pickIdle;
          w_awDoneNext = 1'b0;
          w_wDoneNext  = 1'b0;
          w_stateNext  = ST_XFER;
        end
      end

      ST_XFER: begin
        if (w_awHs) begin
          w_awDoneNext = 1'b1;
        end
        if (w_wLastHs) begin
          w_wDoneNext = 1'b1;
        end
        // AW and the last W beat may finish in either order or together;
        // move on once both are complete, counting this cycle's handshakes.
        if ((r_awDone || w_awHs) && (r_wDone || w_wLastHs)) begin
          w_stateNext = ST_RESP;
        end
      end

      ST_RESP: begin
        if (w_bHs) begin
          w_lastNext = r_g;
          if (w_anyReq) begin
            w_gNext      = w_pickResp;
            w_awDoneNext = 1'b0;
            w_wDoneNext  = 1'b0;
            w_stateNext  = ST_XFER;
          end else begin
            w_stateNext = ST_IDLE;
          end
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase

    if (r_state != ST_IDLE) begin
      if (w_ownerHs) begin
        w_wdCntNext = '0;
      end else if (w_wdExpire) begin
        // Abandon the hung transaction. The owner is pushed to the back of
        // the round-robin order so a stuck master cannot win again at once.
        w_timeoutErrNext = 1'b1;
        w_stateNext      = ST_IDLE;
        w_lastNext       = r_g;
        w_awDoneNext     = 1'b0;
        w_wDoneNext      = 1'b0;
        w_wdCntNext      = '0;
      end else if (WD_EN) begin
        w_wdCntNext = r_wdCnt + WD_W'(1);
      end
    end
  end

  // State registers. Reset is synchronous and restores every register, so a
  // reset in the middle of a transaction leaves nothing behind. The pointer
  // resets to the highest index so that master 0 has top priority first.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state      <= ST_IDLE;
      r_g          <= '0;
      r_last       <= ID_W'(NUM_MASTERS - 1);
      r_awDone     <= 1'b0;
      r_wDone      <= 1'b0;
      r_wdCnt      <= '0;
      r_timeoutErr <= 1'b0;
    end else begin
      r_state      <= w_stateNext;
      r_g          <= w_gNext;
      r_last       <= w_lastNext;
      r_awDone     <= w_awDoneNext;
      r_wDone      <= w_wDoneNext;
      r_wdCnt      <= w_wdCntNext;
      r_timeoutErr <= w_timeoutErrNext;
    end
  end

  // Outputs come straight from registers so the interconnect muxes see a
  // grant that is stable for the whole cycle and glitch-free.
  assign busy        = (r_state != ST_IDLE);
  assign grnt_id     = r_g;
  assign m_wgrnt     = busy ? (NUM_MASTERS'(1) << r_g) : '0;
  assign timeout_err = r_timeoutErr;

endmodule

// File: tb/tb_axi_wr_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_axi_wr_arbiter_rr
//
// Directed bench for axi_wr_arbiter_rr with four masters and an 8-cycle
// watchdog. A transaction-level reference model tracks the owner, the
// round-robin pointer and a watchdog deadline expressed as an absolute cycle
// number; a compare process checks every output against it on each falling
// edge. Directed sequences add literal expectations at key cycles.
// ---------------------------------------------------------------------------
module tb_axi_wr_arbiter_rr;

  localparam int NM         = 4;
  localparam int TB_TIMEOUT = 8;

  logic          ACLK;
  logic          ARESET;
  logic [NM-1:0] m_AWVALID;
  logic [NM-1:0] m_WVALID;
  logic [NM-1:0] m_WLAST;
  logic [NM-1:0] m_BREADY;
  logic          s_AWREADY;
  logic          s_WREADY;
  logic          s_BVALID;
  logic [NM-1:0] m_wgrnt;
  logic [1:0]    grnt_id;
  logic          busy;
  logic          timeout_err;

  int vecCount  = 0;
  int missCount = 0;
  bit checkEn   = 1'b0;

  axi_wr_arbiter_rr #(
    .NUM_MASTERS(NM),
    .ID_W(2),
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .m_AWVALID(m_AWVALID),
    .m_WVALID(m_WVALID),
    .m_WLAST(m_WLAST),
    .m_BREADY(m_BREADY),
    .s_AWREADY(s_AWREADY),
    .s_WREADY(s_WREADY),
    .s_BVALID(s_BVALID),
    .m_wgrnt(m_wgrnt),
    .grnt_id(grnt_id),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  // Free-running clock, 10 time units per cycle.
  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  // Reference model state. mOwner is -1 when nobody owns the path; mG keeps
  // the last owner index because grnt_id holds it after release.
  int     mOwner   = -1;
  int     mG       = 0;
  int     mLast    = NM - 1;
  bit     mAw      = 1'b0;
  bit     mW       = 1'b0;
  bit     mResp    = 1'b0;
  bit     mErr     = 1'b0;
  longint cyc      = 0;
  longint deadline = 0;

  // Round robin as stated: scan last+1, last+2, ..., last modulo NM.
  function automatic int pickNext(input logic [NM-1:0] req, input int from);
    for (int k = 1; k <= NM; k++) begin
      int idx;
      idx = (from + k) % NM;
      if ((req & NM'(1 << idx)) != '0) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NM-1:0] ownerMask(input int who);
    if (who < 0) return '0;
    return NM'(1 << who);
  endfunction

  // Comparison helper shared by the compare process and the directed checks.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
               name, actual, expected, $time);
    end
  endtask

  // Model update at each rising edge from the inputs held over the cycle.
  // The watchdog is kept as an absolute deadline: whenever the owner is
  // granted or makes progress at edge n, the abort happens at edge
  // n+TIMEOUT unless more progress arrives first.
  always @(posedge ACLK) begin
    logic [NM-1:0] om;
    bit awHs;
    bit wBeat;
    bit progress;
    int nxt;
    cyc++;
    if (ARESET) begin
      mOwner = -1;
      mG     = 0;
      mLast  = NM - 1;
      mAw    = 1'b0;
      mW     = 1'b0;
      mResp  = 1'b0;
      mErr   = 1'b0;
    end else if (mOwner < 0) begin
      nxt = pickNext(m_AWVALID, mLast);
      if (nxt >= 0) begin
        mOwner   = nxt;
        mG       = nxt;
        mAw      = 1'b0;
        mW       = 1'b0;
        mResp    = 1'b0;
        deadline = cyc + TB_TIMEOUT;
      end
    end else begin
      om       = ownerMask(mOwner);
      progress = 1'b0;
      if (!mResp) begin
        awHs  = !mAw && ((m_AWVALID & om) != '0) && s_AWREADY;
        wBeat = !mW && ((m_WVALID & om) != '0) && s_WREADY;
        if (awHs) mAw = 1'b1;
        if (wBeat && ((m_WLAST & om) != '0)) mW = 1'b1;
        if (mAw && mW) mResp = 1'b1;
        progress = awHs || wBeat;
      end else if (s_BVALID && ((m_BREADY & om) != '0)) begin
        progress = 1'b1;
        mLast    = mOwner;
        nxt      = pickNext(m_AWVALID, mLast);
        mAw      = 1'b0;
        mW       = 1'b0;
        mResp    = 1'b0;
        mOwner   = nxt;
        if (nxt >= 0) mG = nxt;
      end
      if (progress) begin
        deadline = cyc + TB_TIMEOUT;
      end else if (cyc == deadline) begin
        mErr   = 1'b1;
        mLast  = mOwner;
        mOwner = -1;
        mAw    = 1'b0;
        mW     = 1'b0;
        mResp  = 1'b0;
      end
    end
  end

  // Every cycle, away from the rising edge, all outputs must match the model.
  always @(negedge ACLK) begin
    if (checkEn) begin
      checkOutput("model_busy", 32'(busy), 32'(mOwner >= 0));
      checkOutput("model_wgrnt", 32'(m_wgrnt), 32'(ownerMask(mOwner)));
      checkOutput("model_grnt_id", 32'(grnt_id), 32'(mG));
      checkOutput("model_timeout_err", 32'(timeout_err), 32'(mErr));
    end
  end

  // Drive one cycle of inputs, then step to just after the next rising edge,
  // where the registered outputs already show the following cycle.
  task automatic applyStimulus(input logic rst, input logic [NM-1:0] aw,
                               input logic [NM-1:0] wv, input logic [NM-1:0] wl,
                               input logic [NM-1:0] br, input logic awr,
                               input logic wr, input logic bv);
    ARESET    = rst;
    m_AWVALID = aw;
    m_WVALID  = wv;
    m_WLAST   = wl;
    m_BREADY  = br;
    s_AWREADY = awr;
    s_WREADY  = wr;
    s_BVALID  = bv;
    @(posedge ACLK);
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Safety net so the run always ends even if something stalls the bench.
  initial begin
    #200000;
    $display("[TB] FAIL global_time_limit: got timeout, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

  int rrOrder[5] = '{0, 1, 2, 3, 0};

  // Directed sequence of scenarios with literal expectations at key cycles.
  initial begin
    ARESET    = 1'b1;
    m_AWVALID = '0;
    m_WVALID  = '0;
    m_WLAST   = '0;
    m_BREADY  = '0;
    s_AWREADY = 1'b0;
    s_WREADY  = 1'b0;
    s_BVALID  = 1'b0;
    @(posedge ACLK);
    #1;
    checkEn = 1'b1;

    // Reset held for three edges, then ten quiet cycles.
    applyStimulus(1'b1, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    $display("[TB] reset and idle");
    for (int i = 0; i < 10; i++) begin
      idleCycle();
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_wgrnt", 32'(m_wgrnt), 32'd0);
      checkOutput("idle_grnt_id", 32'(grnt_id), 32'd0);
      checkOutput("idle_timeout_err", 32'(timeout_err), 32'd0);
    end

    // All four request; each owner does AW plus a two-beat W, then B.
    $display("[TB] round robin");
    applyStimulus(1'b0, 4'hF, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("rr_grnt_id", 32'(grnt_id), 32'(rrOrder[i]));
      checkOutput("rr_wgrnt", 32'(m_wgrnt), 32'(4'b0001 << rrOrder[i]));
      applyStimulus(1'b0, 4'hF, 4'hF, 4'h0, 4'hF, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, (i == 4) ? 4'h0 : 4'hF, 4'h0, 4'h0, 4'hF,
                    1'b0, 1'b0, 1'b1);
    end
    checkOutput("rr_end_busy", 32'(busy), 32'd0);

    // Master 2 alone: last W beat two cycles before AW; a B offered while
    // still in XFER must be ignored, and BREADY low must hold the grant.
    $display("[TB] ordering W before AW");
    applyStimulus(1'b0, 4'b0100, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("ord1_grant", 32'(m_wgrnt), 32'h4);
    applyStimulus(1'b0, 4'b0100, 4'b0100, 4'b0100, '0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 4'b0100, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0100, '0, '0, 4'b0100, 1'b1, 1'b0, 1'b1);
    checkOutput("ord1_resp_grant", 32'(m_wgrnt), 32'h4);
    applyStimulus(1'b0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
    checkOutput("ord1_hold_grant", 32'(m_wgrnt), 32'h4);
    applyStimulus(1'b0, '0, '0, '0, 4'b0100, 1'b0, 1'b0, 1'b1);
    checkOutput("ord1_release_wgrnt", 32'(m_wgrnt), 32'h0);
    checkOutput("ord1_release_busy", 32'(busy), 32'd0);

    // Master 2: AW and WLAST together, so XFER lasts one cycle.
    $display("[TB] ordering AW with WLAST");
    applyStimulus(1'b0, 4'b0100, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0100, 4'b0100, 4'b0100, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("ord2_resp_grant", 32'(m_wgrnt), 32'h4);
    applyStimulus(1'b0, '0, '0, '0, 4'b0100, 1'b0, 1'b0, 1'b1);
    checkOutput("ord2_release_busy", 32'(busy), 32'd0);
    idleCycle();

    // Master 1 owns; master 3 toggles its lines with every ready high.
    // Master 1 keeps BREADY high so a falsely early RESP would show.
    $display("[TB] isolation");
    applyStimulus(1'b0, 4'b0010, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("iso_grnt_id", 32'(grnt_id), 32'd1);
      applyStimulus(1'b0, (i % 2 == 1) ? 4'b1000 : 4'b0000,
                    (i % 2 == 0) ? 4'b1000 : 4'b0000, 4'b1000,
                    (i % 2 == 1) ? 4'b1010 : 4'b0010, 1'b1, 1'b1, 1'b1);
    end
    checkOutput("iso_grnt_id_hs", 32'(grnt_id), 32'd1);
    applyStimulus(1'b0, 4'b1010, 4'b0010, 4'b0010, 4'b0010, 1'b1, 1'b1, 1'b0);
    checkOutput("iso_resp_grnt_id", 32'(grnt_id), 32'd1);
    applyStimulus(1'b0, 4'b1000, '0, '0, 4'b0010, 1'b0, 1'b0, 1'b1);
    checkOutput("iso_next_grnt_id", 32'(grnt_id), 32'd3);
    checkOutput("iso_next_wgrnt", 32'(m_wgrnt), 32'h8);
    applyStimulus(1'b0, 4'b1000, 4'b1000, 4'b1000, '0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 4'b1000, 1'b0, 1'b0, 1'b1);
    idleCycle();

    // Watchdog: master 0 wins, AWREADY never comes; abort 8 cycles later
    // and master 1, still requesting, takes over.
    $display("[TB] watchdog");
    applyStimulus(1'b0, 4'b0011, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("wd_grnt_id", 32'(grnt_id), 32'd0);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 4'b0011, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    end
    checkOutput("wd_before_busy", 32'(busy), 32'd1);
    checkOutput("wd_before_err", 32'(timeout_err), 32'd0);
    applyStimulus(1'b0, 4'b0011, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("wd_fire_err", 32'(timeout_err), 32'd1);
    checkOutput("wd_fire_busy", 32'(busy), 32'd0);
    checkOutput("wd_fire_wgrnt", 32'(m_wgrnt), 32'h0);
    applyStimulus(1'b0, 4'b0011, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("wd_next_grnt_id", 32'(grnt_id), 32'd1);
    checkOutput("wd_next_wgrnt", 32'(m_wgrnt), 32'h2);
    applyStimulus(1'b0, 4'b0010, 4'b0010, 4'b0010, '0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 4'b0010, 1'b0, 1'b0, 1'b1);
    checkOutput("wd_sticky_err", 32'(timeout_err), 32'd1);
    idleCycle();

    // Reset while master 3 waits in RESP, then all four request.
    $display("[TB] reset during response");
    applyStimulus(1'b0, 4'b1000, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_owner", 32'(grnt_id), 32'd3);
    applyStimulus(1'b0, 4'b1000, 4'b1000, 4'b1000, '0, 1'b1, 1'b1, 1'b0);
    checkOutput("rst_resp_wgrnt", 32'(m_wgrnt), 32'h8);
    applyStimulus(1'b1, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_wgrnt", 32'(m_wgrnt), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_err", 32'(timeout_err), 32'd0);
    applyStimulus(1'b0, 4'hF, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    checkOutput("rst_winner_id", 32'(grnt_id), 32'd0);
    checkOutput("rst_winner_wgrnt", 32'(m_wgrnt), 32'h1);
    applyStimulus(1'b0, 4'hF, 4'hF, 4'hF, '0, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, '0, '0, '0, 4'hF, 1'b0, 1'b0, 1'b1);
    idleCycle();
    idleCycle();

    @(negedge ACLK);
    #1;
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/axi_wr_arbiter_rr.md
# axi_wr_arbiter_rr

Parametrised AXI write-channel arbiter for the bus interconnect. It grants one of `NUM_MASTERS` masters ownership of the shared AW/W/B path for exactly one write transaction, from AW request to B handshake, using round-robin priority. It adds a stall watchdog that reports and recovers from a hung transaction. It drives grant vectors only; the interconnect muxes use them to steer AW/W/B signals.

## Interface
- `NUM_MASTERS`, 4, number of masters (2..16)
- `ID_W`, `$clog2(NUM_MASTERS)`, width of `grnt_id`
- `TIMEOUT`, 1024, stall-watchdog limit in cycles; 0 disables the watchdog

- `ACLK`  in  1  clock; all logic on rising edge
- `ARESET`  in  1  reset, synchronous, active-high
- `m_AWVALID`  in  NUM_MASTERS  per-master AWVALID
- `m_WVALID`  in  NUM_MASTERS  per-master WVALID
- `m_WLAST`  in  NUM_MASTERS  per-master WLAST
- `m_BREADY`  in  NUM_MASTERS  per-master BREADY
- `s_AWREADY`  in  1  shared slave-side AWREADY
- `s_WREADY`  in  1  shared slave-side WREADY
- `s_BVALID`  in  1  shared slave-side BVALID
- `m_wgrnt`  out  NUM_MASTERS  one-hot grant; all-zero when no owner
- `grnt_id`  out  ID_W  index of current owner; valid when `busy`
- `busy`  out  1  transaction in progress (state ≠ IDLE)
- `timeout_err`  out  1  sticky watchdog flag

## Operation
- States: IDLE, XFER, RESP. Owner register `g`, round-robin pointer `last`, flags `aw_done` and `w_done`, watchdog counter `wd_cnt`.
- Request: a master requests when its `m_AWVALID[i]` is set. A W beat presented without AW is not a request.
- Arbitration: the winner is the first requesting index searching `last+1, last+2, … , last` (mod NUM_MASTERS). The previous owner therefore has lowest priority.
- IDLE: if any request, latch the winner into `g`, clear the flags, and go to XFER.
- XFER:
  - Set `aw_done` on `m_AWVALID[g] & s_AWREADY`.
  - Set `w_done` on `m_WVALID[g] & s_WREADY & m_WLAST[g]`.
  - When both are set, or the final one is set in the same cycle, go to RESP.
  - AW and W handshakes complete in either order or simultaneously.
- RESP: on `s_BVALID & m_BREADY[g]`, set `last <= g`.
  - If any request exists, arbitrate using the updated pointer. The new owner may be the same master only if no other master requests. Go to XFER with the new `g`.
  - If no request exists, go to IDLE.
- Handshakes from non-owner masters are ignored and never change the flags.
- Watchdog (TIMEOUT>0): `wd_cnt` counts cycles in XFER/RESP.
  - Any owner handshake (AW, W beat, or B) clears it; entering IDLE clears it.
  - When `wd_cnt == TIMEOUT-1` with no handshake that cycle: set `timeout_err`, force IDLE, drop the grant, and set `last <= g`.
  - `timeout_err` clears only on `ARESET`.
- Outputs are decoded from registers only: `m_wgrnt = busy ? onehot(g) : 0`, `grnt_id = g`, `busy = (state != IDLE)`.

## Timing
- Reset values: state IDLE, `m_wgrnt` 0, `grnt_id` 0, `busy` 0, `timeout_err` 0, `last` NUM_MASTERS-1 (master 0 highest priority first), flags 0, `wd_cnt` 0.
- `ARESET` asserted mid-transaction returns everything to reset values at the next edge. No partial state is retained.
- Grant latency: request seen in IDLE at cycle N, so `m_wgrnt` is valid in cycle N+1. The AW handshake can occur no earlier than N+1.
- Release: B handshake at cycle M, so the next owner's grant is valid at M+1 with no idle bubble. With no pending request, `m_wgrnt`=0 at M+1.
- Grant is stable from XFER entry until the cycle after the B handshake. It never changes within a transaction.
- Single-beat write with AW and WLAST in the same cycle: XFER lasts 1 cycle.
- Watchdog fires exactly TIMEOUT cycles after the last owner handshake, or after XFER entry if none occurred. Grant drops in the following cycle.

## Test plan
- Reset/idle: hold `ARESET` for 3 cycles with all inputs 0, then release. Required: all outputs 0 and `busy`=0 for 10 cycles.
- Round-robin (NUM_MASTERS=4): all four `m_AWVALID` held high; each transaction is 1 AW, a 2-beat W, and 1 B. Required: grant order 0,1,2,3,0, and each new grant appears one cycle after the previous B handshake.
- Ordering: master 2 alone. Case 1: W with WLAST handshakes 2 cycles before AW. Case 2: AW and WLAST in the same cycle. Required: RESP entered the cycle after both flags are set; grant held until `s_BVALID & m_BREADY[2]`.
- Isolation: master 1 owns the bus; master 3 toggles AWVALID/WVALID/BREADY with ready signals high. Required: no flag or state change, `grnt_id`=1 throughout, master 3 granted after master 1's B.
- Watchdog: TIMEOUT=8; master 0 granted, `s_AWREADY` held 0. Required: `timeout_err`=1 and state IDLE 8 cycles after grant. Master 1 (requesting) is granted next. `timeout_err` clears only on `ARESET`.
- Reset mid-RESP: assert `ARESET` while in RESP with master 3 owner. Required: `m_wgrnt`=0 the next cycle; after release, master 0 wins when all masters request.
